// File: rtl/player_ctrl.sv
// rtl/player_ctrl.sv - player sprite position, lives and alive/shoot/hit/dead control.
// Optional blinking while hit is enabled by defining PLAYER_BLINK_EN.
module player_ctrl #(
    parameter int OBJECT_WIDTH_X = 40,
    parameter int OBJECT_HEIGHT_Y = 40,
    parameter int SCREEN_WIDTH = 640,
    parameter int START_X = 300,
    parameter int PLAYER_Y = 400,
    parameter int SPEED = 4,
    parameter int LIVES = 3,
    parameter int FREEZE_FRAMES = 8,
    parameter int HIT_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        leftKey,
    input  logic        rightKey,
    input  logic        shootKey,
    input  logic        restartKey,
    input  logic        hitBall,
    input  logic        ropeBusy,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        insideRectangle,
    output logic        fire,
    output logic [1:0]  livesLeft,
    output logic        gameOver
);

    typedef enum logic [1:0] {ALIVE, SHOOT, HIT, DEAD} state_t;

    localparam int CNT_MAX = (HIT_FRAMES > FREEZE_FRAMES) ? HIT_FRAMES : FREEZE_FRAMES;
    localparam int CNT_W = (CNT_MAX < 8) ? 3 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_FRAMES - 1);
    localparam logic [CNT_W-1:0] HIT_LAST = CNT_W'(HIT_FRAMES - 1);
    localparam logic signed [12:0] MAX_X = 13'(SCREEN_WIDTH - OBJECT_WIDTH_X);
    localparam logic signed [12:0] STEP = 13'(SPEED);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [10:0]      x_next;
    logic [1:0]       lives_next;
    logic             fire_next;
    logic             shoot_prev;
    logic             shoot_edge;
    logic signed [12:0] x_ext, x_left, x_right;
    logic [10:0]      x_dec, x_inc;
    logic             rect_x, rect_y, rect, draw;

    assign topLeftY   = 11'(PLAYER_Y);
    assign gameOver   = (state == DEAD);
    assign shoot_edge = shootKey & ~shoot_prev;

    // Extended signed arithmetic so a step left from near 0 clamps instead of wrapping.
    assign x_ext   = signed'({2'b00, topLeftX});
    assign x_left  = x_ext - STEP;
    assign x_right = x_ext + STEP;
    assign x_dec   = (x_left < 13'sd0) ? 11'd0 : x_left[10:0];
    assign x_inc   = (x_right > MAX_X) ? MAX_X[10:0] : x_right[10:0];

    assign rect_x = ({1'b0, pixelX} >= {1'b0, topLeftX}) &&
                    ({1'b0, pixelX} < ({1'b0, topLeftX} + 12'(OBJECT_WIDTH_X)));
    assign rect_y = ({1'b0, pixelY} >= 12'(PLAYER_Y)) &&
                    ({1'b0, pixelY} < 12'(PLAYER_Y + OBJECT_HEIGHT_Y));
    assign rect   = rect_x && rect_y;
`ifdef PLAYER_BLINK_EN
    assign draw = rect && (state != DEAD) && !((state == HIT) && cnt[2]);
`else
    assign draw = rect && (state != DEAD);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ALIVE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        x_next     = topLeftX;
        lives_next = livesLeft;
        cnt_next   = cnt;
        fire_next  = 1'b0;
        unique case (state)
            ALIVE, SHOOT: begin
                if (hitBall) begin
                    lives_next = livesLeft - 2'd1;
                    cnt_next   = '0;
                    state_next = (livesLeft == 2'd1) ? DEAD : HIT;
                end else if (state == ALIVE) begin
                    if (startOfFrame && leftKey && !rightKey) begin
                        x_next = x_dec;
                    end else if (startOfFrame && rightKey && !leftKey) begin
                        x_next = x_inc;
                    end
                    if (shoot_edge && !ropeBusy) begin
                        fire_next  = 1'b1;
                        state_next = SHOOT;
                        cnt_next   = '0;
                    end
                end else if (startOfFrame) begin
                    if (cnt == FREEZE_LAST) begin
                        state_next = ALIVE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            HIT: begin
                if (startOfFrame) begin
                    if (cnt == HIT_LAST) begin
                        state_next = ALIVE;
                        x_next     = 11'(START_X);
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            DEAD: begin
                if (restartKey) begin
                    state_next = ALIVE;
                    lives_next = 2'(LIVES);
                    x_next     = 11'(START_X);
                    cnt_next   = '0;
                end
            end
            default: state_next = ALIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            topLeftX        <= 11'(START_X);
            livesLeft       <= 2'(LIVES);
            cnt             <= '0;
            fire            <= 1'b0;
            shoot_prev      <= 1'b0;
            insideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            topLeftX        <= x_next;
            livesLeft       <= lives_next;
            cnt             <= cnt_next;
            fire            <= fire_next;
            shoot_prev      <= shootKey;
            insideRectangle <= draw;
            offsetX         <= rect ? (pixelX - topLeftX) : 11'd0;
            offsetY         <= rect ? (pixelY - 11'(PLAYER_Y)) : 11'd0;
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// tb/tb_player_ctrl.sv - directed and randomized checks of player_ctrl against a frame-level model.
module tb_player_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        leftKey = 1'b0, rightKey = 1'b0, shootKey = 1'b0;
    logic        restartKey = 1'b0, hitBall = 1'b0, ropeBusy = 1'b0;
    logic [10:0] topLeftX, topLeftY, offsetX, offsetY;
    logic        insideRectangle, fire, gameOver;
    logic [1:0]  livesLeft;

    int passed = 0;
    int total = 0;

`ifdef PLAYER_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    player_ctrl dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY),
        .leftKey(leftKey), .rightKey(rightKey), .shootKey(shootKey),
        .restartKey(restartKey), .hitBall(hitBall), .ropeBusy(ropeBusy),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .offsetX(offsetX), .offsetY(offsetY),
        .insideRectangle(insideRectangle), .fire(fire),
        .livesLeft(livesLeft), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    typedef enum {P_ALIVE, P_SHOOT, P_HIT, P_DEAD} phase_t;
    phase_t m_phase = P_ALIVE;
    int m_x = 300, m_lives = 3, m_frames = 0, m_offx = 0, m_offy = 0;
    bit m_prev = 0, m_fire = 0, m_inside = 0;

    // Reference: what the player looks like after each clock, in frame/life terms.
    task automatic model_step();
        int px, py;
        bit in_box, edge_seen;
        if (reset) begin
            m_phase = P_ALIVE; m_x = 300; m_lives = 3; m_frames = 0;
            m_prev = 0; m_fire = 0; m_inside = 0; m_offx = 0; m_offy = 0;
            return;
        end
        px = int'(pixelX);
        py = int'(pixelY);
        in_box = (px >= m_x) && (px < m_x + 40) && (py >= 400) && (py < 440);
        m_offx = in_box ? px - m_x : 0;
        m_offy = in_box ? py - 400 : 0;
        m_inside = in_box && (m_phase != P_DEAD) &&
                   !(BLINK && m_phase == P_HIT && (m_frames % 8) >= 4);
        edge_seen = shootKey && !m_prev;
        m_prev = shootKey;
        m_fire = 0;
        if ((m_phase == P_ALIVE || m_phase == P_SHOOT) && hitBall) begin
            m_lives = m_lives - 1;
            m_frames = 0;
            m_phase = (m_lives == 0) ? P_DEAD : P_HIT;
        end else if (m_phase == P_ALIVE) begin
            if (startOfFrame && leftKey && !rightKey) m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
            if (startOfFrame && rightKey && !leftKey) m_x = (m_x + 4 > 600) ? 600 : m_x + 4;
            if (edge_seen && !ropeBusy) begin
                m_fire = 1; m_phase = P_SHOOT; m_frames = 0;
            end
        end else if (m_phase == P_SHOOT) begin
            if (startOfFrame) m_frames++;
            if (m_frames == 8) begin m_phase = P_ALIVE; m_frames = 0; end
        end else if (m_phase == P_HIT) begin
            if (startOfFrame) m_frames++;
            if (m_frames == 64) begin m_phase = P_ALIVE; m_frames = 0; m_x = 300; end
        end else if (restartKey) begin
            m_phase = P_ALIVE; m_lives = 3; m_x = 300; m_frames = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp)) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("topLeftX", 32'(topLeftX), m_x);
        chk("topLeftY", 32'(topLeftY), 400);
        chk("livesLeft", 32'(livesLeft), m_lives);
        chk("gameOver", 32'(gameOver), int'(m_phase == P_DEAD));
        chk("fire", 32'(fire), int'(m_fire));
        chk("insideRectangle", 32'(insideRectangle), int'(m_inside));
        chk("offsetX", 32'(offsetX), m_offx);
        chk("offsetY", 32'(offsetY), m_offy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        startOfFrame = 1'b0;
        restartKey = 1'b0;
        hitBall = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            tick();
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("reset_x", 32'(topLeftX), 300);
        chk("reset_lives", 32'(livesLeft), 3);
        chk("reset_fire", 32'(fire), 0);
        chk("reset_inside", 32'(insideRectangle), 0);
        reset = 1'b0;

        // Right clamp then left clamp
        rightKey = 1'b1;
        frames(100);
        chk("clamp_right", 32'(topLeftX), 600);
        rightKey = 1'b0;
        leftKey = 1'b1;
        frames(200);
        chk("clamp_left", 32'(topLeftX), 0);
        leftKey = 1'b0;

        // Mid-run reset returns to spawn
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_mid_x", 32'(topLeftX), 300);

        // Rectangle corners and just outside
        pixelX = 11'd300; pixelY = 11'd400;
        tick();
        chk("rect_tl_in", 32'(insideRectangle), 1);
        chk("rect_tl_off", 32'({offsetX, offsetY}), 0);
        pixelX = 11'd339; pixelY = 11'd439;
        tick();
        chk("rect_br_in", 32'(insideRectangle), 1);
        chk("rect_br_offx", 32'(offsetX), 39);
        chk("rect_br_offy", 32'(offsetY), 39);
        pixelX = 11'd340; pixelY = 11'd420;
        tick();
        chk("rect_out_in", 32'(insideRectangle), 0);
        chk("rect_out_offx", 32'(offsetX), 0);

        // Fire, freeze, busy discard
        shootKey = 1'b1;
        tick();
        chk("fire_pulse", 32'(fire), 1);
        tick();
        chk("fire_single", 32'(fire), 0);
        rightKey = 1'b1;
        frames(8);
        chk("freeze_x", 32'(topLeftX), 300);
        frames(1);
        chk("after_freeze_x", 32'(topLeftX), 304);
        shootKey = 1'b0;
        tick();
        ropeBusy = 1'b1; shootKey = 1'b1;
        tick();
        chk("busy_no_fire", 32'(fire), 0);
        shootKey = 1'b0; ropeBusy = 1'b0;

        // Non-fatal hit, invulnerability, respawn
        pixelX = 11'd310; pixelY = 11'd410;
        hitBall = 1'b1;
        tick();
        chk("hit_lives", 32'(livesLeft), 2);
        frames(4);
        tick();
        chk("blink_off_phase", 32'(insideRectangle), BLINK ? 0 : 1);
        frames(4);
        chk("blink_on_phase", 32'(insideRectangle), 1);
        hitBall = 1'b1;
        tick();
        chk("hit_invuln", 32'(livesLeft), 2);
        frames(55);
        chk("hit_frozen_x", 32'(topLeftX), 304);
        frames(1);
        chk("respawn_x", 32'(topLeftX), 300);
        rightKey = 1'b0;

        // Down to the last life, then fatal hit with simultaneous shoot edge
        hitBall = 1'b1;
        tick();
        frames(64);
        chk("lives_one", 32'(livesLeft), 1);
        hitBall = 1'b1; shootKey = 1'b1;
        tick();
        chk("fatal_no_fire", 32'(fire), 0);
        chk("fatal_gameover", 32'(gameOver), 1);
        tick();
        chk("dead_hidden", 32'(insideRectangle), 0);
        shootKey = 1'b0;
        restartKey = 1'b1;
        tick();
        chk("restart_lives", 32'(livesLeft), 3);
        chk("restart_alive", 32'(gameOver), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            startOfFrame = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) leftKey = ~leftKey;
            if ($urandom_range(0, 7) == 0) rightKey = ~rightKey;
            if ($urandom_range(0, 5) == 0) shootKey = ~shootKey;
            restartKey = ($urandom_range(0, 19) == 0);
            hitBall = ($urandom_range(0, 39) == 0);
            ropeBusy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                pixelX = 11'(((m_x - 5 + int'($urandom_range(0, 50))) < 0) ? 0 :
                             (m_x - 5 + int'($urandom_range(0, 50))));
                pixelY = 11'($urandom_range(395, 445));
            end else begin
                pixelX = 11'($urandom_range(0, 799));
                pixelY = 11'($urandom_range(0, 524));
            end
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
